// File: rtl/rv_pkg.sv
// rv_pkg: shared widths, writeback request type and x0 constant
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
  localparam logic [REG_AW-1:0] X0 = '0;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: LSU load-return handshake and register file write port
interface wb_arbiter_if;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [rv_pkg::REG_AW-1:0] ld_rd;
  logic [rv_pkg::XLEN-1:0]   ld_data;
  logic                      rd_wren;
  logic [rv_pkg::REG_AW-1:0] rd_addr;
  logic [rv_pkg::XLEN-1:0]   rd_data;
  modport slave  (input ld_valid, ld_rd, ld_data, output ld_ready, rd_wren, rd_addr, rd_data);
  modport master (output ld_valid, ld_rd, ld_data, input ld_ready, rd_wren, rd_addr, rd_data);
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests with count/full/empty
module wb_fifo
  import rv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       din,
  output wb_req_t       dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  wb_req_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp == LAST ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == LAST ? '0 : rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and buffered load returns into the register
// file write port, and tracks pending loads for the decode hazard check
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_issue_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              hazard_o,
  output logic [NREG-1:0]   busy_o,
  output logic              err_o,
  wb_arbiter_if.slave       wb
);
  localparam int CW = $clog2(LD_DEPTH + 1);
  wb_req_t head, sel;
  logic [CW-1:0] count;
  logic full, empty, ld_acc, sel_head, sel_byp, sel_any, ld_wr, bad;
  logic [NREG-1:0] busy_set, busy_clr;
  assign wb.ld_ready = count < CW'(LD_DEPTH);
  assign ld_acc      = wb.ld_valid && wb.ld_ready;
  assign hazard_o    = (dec_rs1 != X0 && busy_o[dec_rs1]) ||
                       (dec_rs2 != X0 && busy_o[dec_rs2]) ||
                       (dec_rd  != X0 && busy_o[dec_rd]);
  always_comb begin
    sel_head = !alu_valid && !empty;
    sel_byp  = !alu_valid && empty && ld_acc;
    sel_any  = alu_valid || sel_head || sel_byp;
    sel      = alu_valid ? wb_req_t'({alu_rd, alu_data}) :
               sel_head  ? head : wb_req_t'({wb.ld_rd, wb.ld_data});
    ld_wr    = (sel_head || sel_byp) && sel.rd != X0;
    busy_clr = ld_wr ? NREG'(1) << sel.rd : '0;
    busy_set = ld_issue && ld_issue_rd != X0 ? NREG'(1) << ld_issue_rd : '0;
    bad      = (alu_valid && busy_o[alu_rd]) ||
               (ld_acc && wb.ld_rd != X0 && !busy_o[wb.ld_rd]) ||
               (wb.ld_valid && full);
  end
  wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ld_acc && !sel_byp),
    .pop   (sel_head),
    .din   (wb_req_t'({wb.ld_rd, wb.ld_data})),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // set after clear so a same-edge reissue keeps the register pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb.rd_wren <= 1'b0;
      wb.rd_addr <= '0;
      wb.rd_data <= '0;
      busy_o     <= '0;
      err_o      <= 1'b0;
    end else begin
      wb.rd_wren <= sel_any && sel.rd != X0;
      if (sel_any) begin
        wb.rd_addr <= sel.rd;
        wb.rd_data <= sel.data;
      end
      busy_o <= ((busy_o & ~busy_clr) | busy_set) & ~NREG'(1);
      if (bad) err_o <= 1'b1;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a write-port scoreboard
module tb_wb_arbiter;
  import rv_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_valid, ld_issue, hazard_o, err_o;
  logic [4:0] alu_rd, ld_issue_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] alu_data, busy_o;
  wb_req_t exp_q[$];
  wb_req_t mon_e;
  int checks = 0;
  int failures = 0;
  wb_arbiter_if bus();
  wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .hazard_o    (hazard_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .wb          (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    alu_valid = 1'b0;
    ld_issue = 1'b0;
    bus.ld_valid = 1'b0;
  endtask
  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask
  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd = rd;
    alu_data = d;
  endtask
  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_rd = rd;
    bus.ld_data = d;
  endtask
  task automatic issue(input logic [4:0] rd);
    ld_issue = 1'b1;
    ld_issue_rd = rd;
  endtask
  always @(negedge clk)
    if (rst_n && bus.rd_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got x%0d=%h expected none", bus.rd_addr, bus.rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.rd_addr), 32'(mon_e.rd));
        chk("wr_data", bus.rd_data, mon_e.data);
      end
    end
  initial begin
    idle();
    alu_rd = '0; alu_data = '0; ld_issue_rd = '0;
    bus.ld_rd = '0; bus.ld_data = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    #12;
    chk("rst_wren", 32'(bus.rd_wren), 0);
    chk("rst_addr", 32'(bus.rd_addr), 0);
    chk("rst_data", bus.rd_data, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", 32'(err_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_ready", 32'(bus.ld_ready), 1);
    // ALU only
    alu(5, 32'hDEADBEEF); exp_wr(5, 32'hDEADBEEF); tick(); idle();
    chk("alu_wren", 32'(bus.rd_wren), 1);
    tick();
    chk("alu_wren_drop", 32'(bus.rd_wren), 0);
    chk("idle_hold_addr", 32'(bus.rd_addr), 5);
    // load bypass and scoreboard
    issue(7); tick(); idle();
    chk("busy7_set", 32'(busy_o[7]), 1);
    dec_rs1 = 7; #1;
    chk("hazard7", 32'(hazard_o), 1);
    tick();
    ld(7, 32'h1234); exp_wr(7, 32'h1234); tick(); idle();
    chk("byp_wren", 32'(bus.rd_wren), 1);
    chk("busy7_clr", 32'(busy_o[7]), 0);
    chk("hazard7_clr", 32'(hazard_o), 0);
    dec_rs1 = 0;
    // contention
    for (int i = 9; i < 12; i++) begin issue(5'(i)); tick(); end
    idle();
    alu(3, 32'h11); ld(9, 32'h22); exp_wr(3, 32'h11); exp_wr(9, 32'h22); tick(); idle();
    tick();
    chk("busy9_clr", 32'(busy_o[9]), 0);
    issue(9); tick(); idle();
    alu(1, 32'hA1); ld(9, 32'h90); exp_wr(1, 32'hA1); tick();
    alu(2, 32'hA2); ld(10, 32'hA0); exp_wr(2, 32'hA2); tick(); idle();
    exp_wr(9, 32'h90); tick();
    alu(4, 32'hA4); ld(11, 32'hB0); exp_wr(4, 32'hA4); tick(); idle();
    exp_wr(10, 32'hA0); exp_wr(11, 32'hB0); tick(); tick(); tick();
    chk("err_clean", 32'(err_o), 0);
    // FIFO full and drop
    for (int i = 12; i < 15; i++) begin issue(5'(i)); tick(); end
    idle();
    alu(20, 32'hC0); ld(12, 32'h120); exp_wr(20, 32'hC0); tick();
    alu(21, 32'hC1); ld(13, 32'h130); exp_wr(21, 32'hC1); tick();
    chk("full_ready", 32'(bus.ld_ready), 0);
    alu(22, 32'hC2); ld(14, 32'h140); exp_wr(22, 32'hC2); tick(); idle();
    chk("drop_err", 32'(err_o), 1);
    exp_wr(12, 32'h120); exp_wr(13, 32'h130); tick(); tick();
    chk("drain_ready", 32'(bus.ld_ready), 1);
    dec_rd = 14; #1;
    chk("hazard_rd14", 32'(hazard_o), 1);
    dec_rd = 0;
    // x0 and collision
    alu(0, 32'h55); tick(); idle();
    chk("x0_wren", 32'(bus.rd_wren), 0);
    issue(4); tick(); idle();
    ld(4, 32'h44); issue(4); exp_wr(4, 32'h44); tick(); idle();
    chk("collide_wren", 32'(bus.rd_wren), 1);
    chk("collide_busy4", 32'(busy_o[4]), 1);
    // async reset mid-stream
    ld(4, 32'h4A); exp_wr(4, 32'h4A); tick();
    ld(14, 32'hE); exp_wr(14, 32'hE); tick(); idle();
    issue(7); tick(); idle();
    alu(1, 32'h111); ld(7, 32'h77); exp_wr(1, 32'h111); tick(); idle();
    chk("pre_rst_busy", busy_o, 32'h80);
    chk("pre_rst_err", 32'(err_o), 1);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("arst_wren", 32'(bus.rd_wren), 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_err", 32'(err_o), 0);
    chk("arst_ready", 32'(bus.ld_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) tick();
    chk("pending_writes", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side producer for the register file write port (rd_wren/rd_addr/rd_data).
- Merges two result sources into the single write port:
  - single-cycle ALU results;
  - variable-latency load returns from the LSU, buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard and gives decode a combinational hazard/stall signal.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of architectural registers; address width is $clog2(NREG).
- LD_DEPTH, 2, load-return FIFO depth; must be >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid this cycle; no backpressure, always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending.
- ld_issue_rd  in  5  destination register of the issued load.
- ld_valid  in  1  LSU load-return valid.
- ld_ready  out  1  FIFO can accept a load return.
- ld_rd  in  5  load-return destination register.
- ld_data  in  XLEN  load-return data.
- dec_rs1  in  5  decode source 1, checked for hazard.
- dec_rs2  in  5  decode source 2, checked for hazard.
- dec_rd  in  5  decode destination, checked for WAW.
- hazard_o  out  1  decode must stall.
- busy_o  out  NREG  scoreboard bits, for debug/visibility.
- rd_wren  out  1  register file write enable.
- rd_addr  out  5  register file write address.
- rd_data  out  XLEN  register file write data.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst_n low, async): rd_wren=0, rd_addr=0, rd_data=0, busy_o=0, FIFO emptied, err_o=0, ld_ready=1 after release.
  - Reset mid-operation discards all buffered loads and pending bits.
- The write port is registered: the source selected in cycle N appears on rd_* after the rising edge ending cycle N.
- rd_wren is high for exactly one cycle per write.
- Priority, evaluated each cycle:
  - alu_valid wins.
  - Else FIFO head, if FIFO is non-empty.
  - Else bypass of ld_valid when FIFO is empty (load latency 1 cycle).
  - Else idle (rd_wren=0; rd_addr and rd_data hold their previous values).
- FIFO:
  - Enqueue when ld_valid && ld_ready, unless the beat is consumed by the bypass.
  - Dequeue when the head is selected.
  - ld_ready = (count < LD_DEPTH). It is not raised by a same-cycle dequeue.
  - Simultaneous enqueue and dequeue keeps count unchanged.
  - Pointers wrap modulo LD_DEPTH.
  - Order is strictly FIFO.
- x0 handling:
  - Any selected write with rd==0 drives rd_wren=0 but still consumes the entry.
  - ld_issue with rd 0 sets nothing.
- Scoreboard:
  - ld_issue sets busy[ld_issue_rd] at the clock edge.
  - A load write (head or bypass) clears busy[rd] at the same edge rd_wren rises.
  - Same-edge set and clear of the same register: set wins.
  - busy[0] is always 0.
- hazard_o is combinational: busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], each term ignored when its address is 0.
- err_o is set (sticky until reset) on any of:
  - alu_valid to a register whose busy bit is set;
  - a load return whose rd has busy=0;
  - ld_valid while ld_ready=0.
  - The offending beat is still processed, except that a beat arriving with ld_ready=0 is dropped.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and REG_AW=5;
  - typedef wb_req_t {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;};
  - localparam X0 = '0.
- One sub-module, wb_fifo: a parameterised synchronous FIFO of wb_req_t with count/full/empty, async active-low reset.
- Arbitration and the scoreboard stay in wb_arbiter.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle rd_wren=1, rd_addr=5, rd_data=0xDEADBEEF; the cycle after, rd_wren=0.
- Load bypass plus scoreboard:
  - ld_issue rd=7 -> busy_o[7]=1, and hazard_o=1 with dec_rs1=7.
  - Two cycles later, ld_valid rd=7, data=0x1234, FIFO empty, no ALU -> next edge rd_wren=1, rd_addr=7, rd_data=0x1234, busy_o[7]=0, hazard_o=0.
- Contention:
  - Same cycle alu_valid rd=3 data=0x11 and ld_valid rd=9 (pending) data=0x22 -> write x3=0x11 first, then x9=0x22 one cycle later from the FIFO.
  - Order is preserved across three loads to 9, 10, 11 held under continuous ALU traffic.
- FIFO full: continuous alu_valid while two loads arrive -> ld_ready=0 when count=2.
  - A third ld_valid in that state is dropped and sets err_o=1.
  - Dropping ALU traffic drains both loads in order.
- x0 and collision:
  - alu_valid rd=0 -> rd_wren stays 0.
  - ld_issue rd=4 on the same edge that a load to 4 writes back -> busy_o[4] remains 1.
- Async reset mid-stream: assert rst_n=0 with the FIFO holding 1 entry and busy_o=0x80 -> immediately rd_wren=0, busy_o=0, err_o=0.
  - After release, no stale write appears.
